// File: rtl/krgen_stream.sv
`default_nettype none
// ============================================================================
// krgen_stream : streaming Ling group pseudo-carry (k) / group propagate (r)
//                generator over a SPAN-bit window, multi-beat packets
// Revision     : 1.0
// ============================================================================
module krgen_stream #(
    parameter int WIDTH = 64,
    parameter int SPAN  = 4,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  logic             in_last,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_first,
    output logic             out_last,
    output logic             out_seq_err,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] r
);
    localparam int HW = SPAN - 1;
    localparam int XW = WIDTH + HW;
    localparam int PW = 2 * WIDTH + 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_INPKT = 1'b1
    } state_t;

    state_t           state_q;
    logic [HW-1:0]    hg_q;
    logic [HW-1:0]    hp_q;

    logic             accept;
    logic             start;
    logic             seq_err;
    logic [XW-1:0]    xg;
    logic [XW-1:0]    xp;
    logic [WIDTH-1:0] k_d;
    logic [WIDTH-1:0] r_d;
    logic             term;
    logic [LAT-1:0]   adv;
    logic [LAT-1:0]   vld_all;

    assign accept  = in_valid & in_ready;
    // A beat arriving in IDLE always opens a packet, flagged if in_first was missing.
    assign start   = (state_q == ST_IDLE) | in_first;
    assign seq_err = (state_q == ST_IDLE) & ~in_first;

    assign xg = {g, start ? {HW{1'b0}} : hg_q};
    assign xp = {p, start ? {HW{1'b1}} : hp_q};

    always_comb begin
        k_d  = '0;
        r_d  = '0;
        term = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            r_d[i] = &xp[i +: SPAN];
            for (int j = 0; j < SPAN; j++) begin
                term = xg[i + HW - j];
                for (int m = 1; m < j; m++) begin
                    term = term & xp[i + HW - m];
                end
                k_d[i] = k_d[i] | term;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hg_q    <= '0;
            hp_q    <= '1;
        end else if (accept) begin
            state_q <= in_last ? ST_IDLE : ST_INPKT;
            hg_q    <= g[WIDTH-1 -: HW];
            hp_q    <= p[WIDTH-1 -: HW];
        end
    end

    // Stage s may load whenever any stage from s up to the output has a hole.
    always_comb begin
        adv = '0;
        for (int s = 0; s < LAT; s++) begin
            adv[s] = out_ready;
            for (int t = s; t < LAT; t++) begin
                if (!vld_all[t]) begin
                    adv[s] = 1'b1;
                end
            end
        end
    end

    assign in_ready = adv[0];

    generate
        for (genvar s = 0; s < LAT; s++) begin : g_stage
            logic          vin;
            logic [PW-1:0] din;
            logic          vld_q;
            logic [PW-1:0] dat_q;

            if (s == 0) begin : g_head
                assign vin = accept;
                assign din = {k_d, r_d, start, in_last, seq_err};
            end else begin : g_body
                assign vin = g_stage[s-1].vld_q;
                assign din = g_stage[s-1].dat_q;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= 1'b0;
                    dat_q <= '0;
                end else if (adv[s]) begin
                    vld_q <= vin;
                    if (vin) begin
                        dat_q <= din;
                    end
                end
            end

            assign vld_all[s] = vld_q;
        end
    endgenerate

    assign out_valid = vld_all[LAT-1];
    assign {k, r, out_first, out_last, out_seq_err} = g_stage[LAT-1].dat_q;

endmodule
`default_nettype wire

// File: tb/tb_krgen_stream.sv
`default_nettype none
// tb_krgen_stream : vector table on a LAT=1 instance, hand sequences and a
// scoreboarded random stream on a LAT=2 instance (WIDTH=8, SPAN=4).
module tb_krgen_stream;
    localparam int SPAN = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic       a_valid, a_ready, a_first, a_last, a_ov, a_or, a_of, a_ol, a_oe;
    logic [7:0] a_g, a_p, a_k, a_r;
    logic       b_valid, b_ready, b_first, b_last, b_ov, b_or, b_of, b_ol, b_oe;
    logic [7:0] b_g, b_p, b_k, b_r;

    krgen_stream #(.WIDTH(8), .SPAN(SPAN), .LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready),
        .in_first(a_first), .in_last(a_last), .g(a_g), .p(a_p),
        .out_valid(a_ov), .out_ready(a_or), .out_first(a_of), .out_last(a_ol),
        .out_seq_err(a_oe), .k(a_k), .r(a_r)
    );

    krgen_stream #(.WIDTH(8), .SPAN(SPAN), .LAT(2)) u_lat2 (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready),
        .in_first(b_first), .in_last(b_last), .g(b_g), .p(b_p),
        .out_valid(b_ov), .out_ready(b_or), .out_first(b_of), .out_last(b_ol),
        .out_seq_err(b_oe), .k(b_k), .r(b_r)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] k;
        logic [7:0] r;
        logic       f;
        logic       l;
        logic       e;
    } exp_t;

    typedef struct {
        logic       f;
        logic       l;
        logic [7:0] g;
        logic [7:0] p;
        logic [7:0] k;
        logic [7:0] r;
        logic       ef;
        logic       el;
        logic       ee;
    } vec_t;

    exp_t       sb[$];
    logic       m_inpkt = 1'b0;
    logic [7:0] m_pg = 8'h00;
    logic [7:0] m_pp = 8'hFF;
    int         nout = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bit i carries if some generate at most SPAN-1 places below it reaches i
    // through an unbroken propagate run; r[i] needs SPAN consecutive propagates.
    function automatic logic [15:0] ref_window(input logic [7:0] g, input logic [7:0] p,
                                               input logic [7:0] hg, input logic [7:0] hp);
        logic [15:0] gg, pp;
        logic [7:0]  kk, rr;
        logic        run;
        gg = {g, hg};
        pp = {p, hp};
        kk = '0;
        rr = '0;
        for (int i = 0; i < 8; i++) begin
            for (int q = i + 8 - (SPAN - 1); q <= i + 8; q++) begin
                run = gg[q];
                for (int t = q + 1; t < i + 8; t++) run = run & pp[t];
                kk[i] = kk[i] | run;
            end
            rr[i] = ((pp >> (i + 8 - (SPAN - 1))) & 16'((1 << SPAN) - 1)) == 16'((1 << SPAN) - 1);
        end
        return {kk, rr};
    endfunction

    task automatic monitor();
        exp_t        o, e;
        logic        st;
        logic [15:0] w;
        if (rst) begin
            sb.delete();
            m_inpkt = 1'b0;
            m_pg    = 8'h00;
            m_pp    = 8'hFF;
            return;
        end
        o = '{b_k, b_r, b_of, b_ol, b_oe};
        if (b_ov) begin
            chk("lat2_has_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb[0];
                chk("lat2_beat", 32'(o), 32'(e));
                if (b_or) begin
                    void'(sb.pop_front());
                    nout++;
                end
            end
        end
        if (b_valid && b_ready) begin
            st = !m_inpkt || b_first;
            w  = ref_window(b_g, b_p, st ? 8'h00 : m_pg, st ? 8'hFF : m_pp);
            sb.push_back('{w[15:8], w[7:0], st, b_last, !m_inpkt && !b_first});
            m_inpkt = !b_last;
            m_pg    = b_g;
            m_pp    = b_p;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic b_drive(input logic f, input logic l, input logic [7:0] g, input logic [7:0] p);
        b_valid = 1'b1;
        b_first = f;
        b_last  = l;
        b_g     = g;
        b_p     = p;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [12];
        int   n0;
        vt[0]  = '{1'b1, 1'b1, 8'h01, 8'hFF, 8'h0F, 8'hFF, 1'b1, 1'b1, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 8'h80, 8'hFF, 8'h80, 8'hFF, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 8'h00, 8'hFF, 8'h07, 8'hFF, 1'b0, 1'b1, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 8'h80, 8'hFF, 8'h80, 8'hFF, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 8'h00, 8'hFE, 8'h00, 8'hF0, 1'b1, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 1'b1, 8'h01, 8'hFF, 8'h0F, 8'hFF, 1'b1, 1'b1, 1'b1};
        vt[8]  = '{1'b1, 1'b1, 8'hE0, 8'hFF, 8'hE0, 8'hFF, 1'b1, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1};
        vt[10] = '{1'b0, 1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0};
        vt[11] = '{1'b1, 1'b1, 8'h10, 8'h30, 8'h70, 8'h00, 1'b1, 1'b1, 1'b0};

        rst = 1'b0;
        a_valid = 0; a_first = 0; a_last = 0; a_g = 0; a_p = 0; a_or = 1;
        b_valid = 0; b_first = 0; b_last = 0; b_g = 0; b_p = 0; b_or = 1;
        #1 rst = 1'b1;
        tick();
        tick();
        chk("rst_a_out_valid", 32'(a_ov), 32'd0);
        chk("rst_a_k", 32'(a_k), 32'd0);
        chk("rst_a_r", 32'(a_r), 32'd0);
        chk("rst_a_flags", 32'({a_of, a_ol, a_oe}), 32'd0);
        chk("rst_a_in_ready", 32'(a_ready), 32'd1);
        chk("rst_b_out_valid", 32'(b_ov), 32'd0);
        chk("rst_b_kr", 32'({b_k, b_r}), 32'd0);
        rst = 1'b0;
        tick();

        // Back-to-back table on the single-stage instance.
        for (int n = 0; n < 12; n++) begin
            a_valid = 1'b1;
            a_first = vt[n].f;
            a_last  = vt[n].l;
            a_g     = vt[n].g;
            a_p     = vt[n].p;
            tick();
            chk($sformatf("vec%0d_valid", n), 32'(a_ov), 32'd1);
            chk($sformatf("vec%0d_k", n), 32'(a_k), 32'(vt[n].k));
            chk($sformatf("vec%0d_r", n), 32'(a_r), 32'(vt[n].r));
            chk($sformatf("vec%0d_flags", n), 32'({a_of, a_ol, a_oe}),
                32'({vt[n].ef, vt[n].el, vt[n].ee}));
        end
        a_valid = 1'b0;
        tick();
        chk("lat1_drained", 32'(a_ov), 32'd0);

        // Two-cycle latency.
        b_drive(1'b1, 1'b1, 8'h01, 8'hFF);
        tick();
        b_valid = 1'b0;
        chk("lat2_not_yet", 32'(b_ov), 32'd0);
        tick();
        chk("lat2_arrived", 32'(b_ov), 32'd1);
        tick();
        tick();

        // Backpressure: two beats fill the pipe, third must wait.
        b_or = 1'b0;
        n0   = nout;
        b_drive(1'b1, 1'b0, 8'h01, 8'hFF);
        tick();
        chk("bp_ready_after_1", 32'(b_ready), 32'd1);
        b_drive(1'b0, 1'b0, 8'h80, 8'h7F);
        tick();
        b_drive(1'b0, 1'b1, 8'h04, 8'hF0);
        chk("bp_ready_full", 32'(b_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_ready_held", 32'(b_ready), 32'd0);
            chk("bp_out_held", 32'(b_ov), 32'd1);
        end
        b_or = 1'b1;
        #1;
        chk("bp_ready_comb", 32'(b_ready), 32'd1);
        tick();
        b_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        chk("bp_count", 32'(nout - n0), 32'd3);
        chk("bp_sb_empty", 32'(sb.size()), 32'd0);

        // Asynchronous reset with two beats in flight mid-packet.
        b_or = 1'b0;
        b_drive(1'b1, 1'b0, 8'hE0, 8'hFF);
        tick();
        b_drive(1'b0, 1'b0, 8'hFF, 8'hFF);
        tick();
        b_valid = 1'b0;
        chk("mid_inflight", 32'(b_ov), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_async", 32'(b_ov), 32'd0);
        tick();
        rst  = 1'b0;
        b_or = 1'b1;
        b_drive(1'b0, 1'b1, 8'h00, 8'hFF);
        tick();
        b_valid = 1'b0;
        tick();
        chk("post_rst_valid", 32'(b_ov), 32'd1);
        chk("post_rst_k", 32'(b_k), 32'd0);
        chk("post_rst_first_err", 32'({b_of, b_oe}), 32'b11);
        tick();
        tick();

        // Random stream with random backpressure against the reference model.
        for (int c = 0; c < 400; c++) begin
            b_valid = ($urandom_range(0, 3) != 0);
            b_first = ($urandom_range(0, 5) == 0);
            b_last  = ($urandom_range(0, 3) == 0);
            b_g     = 8'($urandom);
            b_p     = 8'($urandom) | 8'($urandom);
            b_or    = ($urandom_range(0, 3) != 0);
            tick();
        end
        b_valid = 1'b0;
        b_or    = 1'b1;
        for (int c = 0; c < 20 && sb.size() != 0; c++) tick();
        chk("rand_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
